// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Definitions shared by the RV32I core front end.
//   - XLEN             : architectural register / address width
//   - NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   - DEFAULT_RESET_PC : PC of the first fetch after reset
//   - fetch_entry_t    : one prefetch buffer entry, {pc, instr}
//   - align_word()     : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int               XLEN             = 32;
    localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are always word aligned; the low two bits are discarded.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO holding {pc, instr} entries for the fetch unit.
//   The head entry is presented combinationally so decode sees it with no
//   extra cycle of latency. flush has priority over push and pop.
//
//   Ports
//     clk        in   clock, all state on rising edge
//     reset      in   synchronous active-high reset (empties the FIFO)
//     push       in   write push_data (ignored when full)
//     pop        in   drop the head entry (ignored when empty)
//     flush      in   discard all entries; beats push and pop
//     push_data  in   entry to write
//     head_data  out  oldest entry (undefined content when empty)
//     full       out  DEPTH entries held
//     empty      out  no entries held
//     count      out  number of entries held, 0..DEPTH
//
//   Parameters
//     DEPTH      number of entries; power of 2, >= 2
// ---------------------------------------------------------------------------
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push;
    logic            do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in always_comb gets a default at the top of
    // the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only read
    // when count says they are valid, and leaving them unreset keeps them as
    // plain register-file/RAM cells.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end feeding the IF/ID register of the 5-stage
//   RV32I core. Issues PC-ordered requests to a variable-latency instruction
//   memory, buffers the returned words in a prefetch FIFO and presents
//   {instr, pc, pc+4} to decode over a valid/ready handshake. A redirect from
//   execute flushes the buffer and squashes responses still in flight.
//
//   Ports
//     clk             in   clock, all state on rising edge
//     reset           in   synchronous active-high reset (shared with imem)
//     imem_req        out  request valid
//     imem_addr       out  word-aligned fetch address
//     imem_gnt        in   request accepted this cycle
//     imem_rvalid     in   response valid, in order, >= 1 cycle after grant
//     imem_rdata      in   instruction word
//     redirect        in   branch/jump taken in execute
//     redirect_pc     in   new PC, bits [1:0] ignored
//     instr_valid     out  entry available to decode
//     instr_ready     in   decode accepts (low = stall)
//     instr           out  instruction, NOP when !instr_valid
//     instr_pc        out  PC of instr, 0 when !instr_valid
//     instr_pc_plus4  out  instr_pc + 4, 0 when !instr_valid
//
//   Parameters
//     RESET_PC         PC of the first fetch after reset
//     FIFO_DEPTH       prefetch entries; power of 2, >= 2
//     MAX_OUTSTANDING  granted-but-unanswered requests allowed, >= 1
//
//   Build option
//     FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is
//                      empty is shown to decode in the same cycle and only
//                      written to the FIFO if decode stalls.
// ---------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    // instruction memory
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    // redirect from execute
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    // decode handshake
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // State: next PC to request, PC of the next response to keep, requests
    // in flight, and how many of those in-flight responses are stale.
    logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,     resp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   discard_q,     discard_d;

    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            bypass;
    logic            head_valid;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    head;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect),
        .push_data (rsp_entry),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue: a request is only made when there is a guaranteed FIFO slot for
    // its response (buffered + in flight < depth), so the FIFO cannot overflow.
    always_comb begin
        imem_req  = !reset && !redirect
                    && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
                    && ((32'(fifo_count) + 32'(outstanding_q)) < 32'(FIFO_DEPTH));
        imem_addr = fetch_pc_q;
        req_fire  = imem_req && imem_gnt;
    end

    // Response classification. A response with nothing outstanding is a
    // protocol error and is ignored outright.
    always_comb begin
        rsp_fire  = imem_rvalid && !reset && (outstanding_q != '0);
        rsp_drop  = rsp_fire && (redirect || (discard_q != '0));
        rsp_keep  = rsp_fire && !rsp_drop;
        rsp_entry = '{pc: resp_pc_q, instr: imem_rdata};
    end

    // Head selection and decode-facing outputs.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass = rsp_keep && fifo_empty;
`else
        bypass = 1'b0;
`endif
        head_valid = !reset && (!fifo_empty || bypass);
        head       = bypass ? rsp_entry : fifo_head;

        // A bypassed word only needs buffering if decode does not take it now.
        fifo_push  = rsp_keep && !(bypass && instr_ready);
        fifo_pop   = !fifo_empty && instr_ready && !redirect && !reset;

        instr_valid    = head_valid;
        instr          = NOP_INSTR;
        instr_pc       = '0;
        instr_pc_plus4 = '0;
        if (head_valid) begin
            instr          = head.instr;
            instr_pc       = head.pc;
            instr_pc_plus4 = head.pc + 32'd4;
        end
    end

    // Next-state for the PC, credit and discard counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_fire);
        discard_d     = discard_q;

        if (redirect) begin
            fetch_pc_d = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            // Everything still in flight after this edge belongs to the old
            // path; no request is issued on a redirect cycle.
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_keep) resp_pc_d  = resp_pc_q + 32'd4;
            if (rsp_fire && (discard_q != '0)) discard_d = discard_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Responses may only arrive for requests that were granted.
    a_rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (reset) imem_rvalid |-> (outstanding_q != '0));

    // The issue credit rule must keep the FIFO from ever being pushed when full.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule
